// File: rtl/otter_intr_pkg.sv
// Shared definitions for the OTTER interrupt controller: register offsets,
// source limits and the fixed-priority encoder.
package otter_intr_pkg;

  localparam logic [2:0] INTR_PENDING = 3'd0;
  localparam logic [2:0] INTR_ENABLE  = 3'd1;
  localparam logic [2:0] INTR_CAUSE   = 3'd2;
  localparam logic [2:0] INTR_TPERIOD = 3'd3;
  localparam logic [2:0] INTR_TCOUNT  = 3'd4;

  localparam int MAX_SRC = 16;
  localparam int SEL_W   = $clog2(MAX_SRC + 1);

  typedef logic [3:0]       intr_cause_t;
  typedef logic [MAX_SRC:0] prio_vec_t;

  // Lowest set index wins, so source 0 has the highest priority.
  function automatic logic [SEL_W-1:0] prio_enc(input prio_vec_t vec);
    prio_enc = '0;
    for (int i = MAX_SRC; i >= 0; i--) begin
      if (vec[i]) prio_enc = SEL_W'(i);
    end
  endfunction

endpackage

// File: rtl/otter_intr_ctrl_sync.sv
// Two-flop synchroniser followed by rising-edge detection, one bit per source.
// The rise output is a single-cycle pulse driven only from flops.
module intr_sync_edge #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/otter_intr_ctrl.sv
// OTTER interrupt controller: edge-latched pending bits, enable mask, priority
// retirement into CAUSE. Optional periodic timer source under INTR_TIMER_EN.
module otter_intr_ctrl
  import otter_intr_pkg::*;
#(
  parameter int N_SRC   = 8,
  parameter int CAUSE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SRC-1:0]   irq_src,
  input  logic               mie,
  input  logic               int_taken,
  input  logic               mmio_sel,
  input  logic               mmio_we,
  input  logic [2:0]         mmio_addr,
  input  logic [31:0]        mmio_wdata,
  output logic [31:0]        mmio_rdata,
  output logic               intr,
  output logic [CAUSE_W-1:0] cause
);

`ifdef INTR_TIMER_EN
  localparam int PW = N_SRC + 1;
`else
  localparam int PW = N_SRC;
`endif

  logic [N_SRC-1:0]   rise;
  logic [PW-1:0]      set_vec;
  logic [PW-1:0]      pend_q;
  logic [PW-1:0]      pend_d;
  logic [PW-1:0]      en_q;
  logic [PW-1:0]      hit;
  logic [SEL_W-1:0]   sel;
  logic               any_hit;
  logic [CAUSE_W-1:0] cause_q;
  logic               wr_en;

  intr_sync_edge #(.WIDTH(N_SRC)) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (irq_src),
    .rise  (rise)
  );

  assign wr_en   = mmio_sel & mmio_we;
  assign hit     = pend_q & en_q;
  assign any_hit = |hit;
  assign sel     = prio_enc(prio_vec_t'(hit));

`ifdef INTR_TIMER_EN
  logic [31:0] tper_q;
  logic [31:0] tcnt_q;
  logic        t_wrap;

  assign t_wrap = (tper_q != 32'd0) && (tcnt_q == tper_q - 32'd1);

  // Period 0 parks the counter; a period write restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      tper_q <= '0;
      tcnt_q <= '0;
    end else if (wr_en && mmio_addr == INTR_TPERIOD) begin
      tper_q <= mmio_wdata;
      tcnt_q <= '0;
    end else if (tper_q == 32'd0 || t_wrap) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_q + 32'd1;
    end
  end

  assign set_vec = {t_wrap, rise};
`else
  logic unused_wdata;
  assign unused_wdata = ^mmio_wdata[31:PW];
  assign set_vec      = rise;
`endif

  // Clears are applied first so a same-cycle edge always leaves the bit set.
  always_comb begin
    pend_d = pend_q;
    if (wr_en && mmio_addr == INTR_PENDING) pend_d = pend_d & ~mmio_wdata[PW-1:0];
    if (int_taken && any_hit) pend_d = pend_d & ~(PW'(1) << sel);
    pend_d = pend_d | set_vec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= '0;
      en_q    <= '0;
      cause_q <= '0;
    end else begin
      pend_q <= pend_d;
      if (wr_en && mmio_addr == INTR_ENABLE) en_q <= mmio_wdata[PW-1:0];
      if (int_taken && any_hit) cause_q <= CAUSE_W'(sel);
    end
  end

  always_comb begin
    mmio_rdata = '0;
    if (mmio_sel) begin
      case (mmio_addr)
        INTR_PENDING: mmio_rdata = 32'(pend_q);
        INTR_ENABLE:  mmio_rdata = 32'(en_q);
        INTR_CAUSE:   mmio_rdata = 32'(cause_q);
`ifdef INTR_TIMER_EN
        INTR_TPERIOD: mmio_rdata = tper_q;
        INTR_TCOUNT:  mmio_rdata = tcnt_q;
`endif
        default:      mmio_rdata = '0;
      endcase
    end
  end

  assign intr  = mie & any_hit;
  assign cause = cause_q;

endmodule
